// File: rtl/shiftrows_pipe.sv
// Registered ShiftRows/InvShiftRows stage for Nb = 4, 6 or 8 with a 2-entry output FIFO.
// The permutation is applied at the input and only shifted states are buffered.
module shiftrows_pipe #(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4,
    localparam int unsigned W    = 32 * NB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned DEPTH = 2;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shiftrows_pipe: NB must be 4, 6 or 8");
    end

    // Byte i = r + 4c sits at [W-1-8i -: 8]; rows 2 and 3 shift one further when Nb = 8.
    function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] o;
        int unsigned  off;
        int unsigned  sc;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < NB; c++) begin
                off = (NB == 8 && r >= 2) ? r + 1 : r;
                sc  = inv ? (c + NB - off) % NB : (c + off) % NB;
                o[W-1-8*(r+4*c) -: 8] = d[W-1-8*(r+4*sc) -: 8];
            end
        end
        return o;
    endfunction

    logic [W-1:0]     data_mem_q [DEPTH];
    logic [W-1:0]     data_mem_d [DEPTH];
    logic [TAG_W-1:0] tag_mem_q  [DEPTH];
    logic [TAG_W-1:0] tag_mem_d  [DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             accept;
    logic             dequeue;
    logic [W-1:0]     shifted;

    // FIFO bookkeeping; outputs are pre-computed from the post-edge head entry.
    always_comb begin
        data_mem_d = data_mem_q;
        tag_mem_d  = tag_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;
        accept     = in_valid & in_ready_q;
        dequeue    = out_valid_q & out_ready;
        shifted    = shift_rows(in_data, in_inv);

        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (accept) begin
                data_mem_d[wr_ptr_q] = shifted;
                tag_mem_d[wr_ptr_q]  = in_tag;
                wr_ptr_d             = ~wr_ptr_q;
            end
            if (dequeue) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({accept, dequeue})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        in_ready_d  = (count_d < 2'd2);
        out_valid_d = (count_d != 2'd0);
        if (out_valid_d) begin
            out_data_d = data_mem_d[rd_ptr_d];
            out_tag_d  = tag_mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_q[i] <= '0;
                tag_mem_q[i]  <= '0;
            end
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            data_mem_q  <= data_mem_d;
            tag_mem_q   <= tag_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_shiftrows_pipe.sv
// Directed bench for shiftrows_pipe: three instances (Nb = 4, 6, 8) share one handshake.
`timescale 1ns/1ps
module tb_shiftrows_pipe;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_inv;
    logic [3:0]   in_tag;
    logic         out_ready;
    logic [127:0] in_data4;
    logic [191:0] in_data6;
    logic [255:0] in_data8;
    logic         in_ready4, in_ready6, in_ready8;
    logic         out_valid4, out_valid6, out_valid8;
    logic [127:0] out_data4;
    logic [191:0] out_data6;
    logic [255:0] out_data8;
    logic [3:0]   out_tag4, out_tag6, out_tag8;

    int checks;
    int failures;

    localparam logic [127:0] SEQ4  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] SEQ6  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] SEQ8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FWD4  = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] INV4  = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [191:0] FWD6  = 192'h00050a0f04090e13080d12170c11160310150207_1401060b;
    localparam logic [255:0] FWD8  = 256'h00050e130409121708_0d161b0c111a1f10151e0314190207181d060b1c010a0f;
    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    shiftrows_pipe #(.NB(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data4),
        .in_inv(in_inv), .in_tag(in_tag),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .out_tag(out_tag4)
    );

    shiftrows_pipe #(.NB(6), .TAG_W(4)) u_dut6 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready6), .in_data(in_data6),
        .in_inv(in_inv), .in_tag(in_tag),
        .out_valid(out_valid6), .out_ready(out_ready),
        .out_data(out_data6), .out_tag(out_tag6)
    );

    shiftrows_pipe #(.NB(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data8),
        .in_inv(in_inv), .in_tag(in_tag),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .out_tag(out_tag8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [127:0] d4, input logic inv, input logic [3:0] tag);
        in_valid = 1'b1;
        in_data4 = d4;
        in_data6 = SEQ6;
        in_data8 = SEQ8;
        in_inv   = inv;
        in_tag   = tag;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inv    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        in_data4  = '0;
        in_data6  = '0;
        in_data8  = '0;

        #2 rst = 1'b1;
        #1;
        check_eq("rst_in_ready4",  256'(in_ready4),  256'(1));
        check_eq("rst_in_ready6",  256'(in_ready6),  256'(1));
        check_eq("rst_in_ready8",  256'(in_ready8),  256'(1));
        check_eq("rst_out_valid4", 256'(out_valid4), 256'(0));
        check_eq("rst_out_data4",  256'(out_data4),  256'(0));
        check_eq("rst_out_tag4",   256'(out_tag4),   256'(0));
        check_eq("rst_out_valid8", 256'(out_valid8), 256'(0));
        check_eq("rst_out_tag8",   256'(out_tag8),   256'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Back-to-back beats, alternating direction, with out_ready held high.
        out_ready = 1'b1;
        offer(SEQ4, 1'b0, 4'd5);
        tick();
        check_eq("fwd4_valid", 256'(out_valid4), 256'(1));
        check_eq("fwd4_data",  256'(out_data4),  256'(FWD4));
        check_eq("fwd4_tag",   256'(out_tag4),   256'(5));
        check_eq("fwd6_valid", 256'(out_valid6), 256'(1));
        check_eq("fwd6_data",  256'(out_data6),  256'(FWD6));
        check_eq("fwd6_tag",   256'(out_tag6),   256'(5));
        check_eq("fwd8_data",  out_data8,        FWD8);
        offer(SEQ4, 1'b1, 4'd6);
        tick();
        check_eq("inv4_valid", 256'(out_valid4), 256'(1));
        check_eq("inv4_data",  256'(out_data4),  256'(INV4));
        check_eq("inv4_tag",   256'(out_tag4),   256'(6));
        offer(FIPS_IN, 1'b0, 4'd7);
        tick();
        check_eq("fips_fwd", 256'(out_data4), 256'(FIPS_OUT));
        offer(FIPS_OUT, 1'b1, 4'd8);
        tick();
        check_eq("fips_inv",     256'(out_data4), 256'(FIPS_IN));
        check_eq("fips_inv_tag", 256'(out_tag4),  256'(8));
        in_valid = 1'b0;
        tick();
        check_eq("drain_valid", 256'(out_valid4), 256'(0));
        check_eq("drain_ready", 256'(in_ready4),  256'(1));

        // Backpressure: two beats fill the buffer, the third stalls.
        out_ready = 1'b0;
        offer(SEQ4, 1'b0, 4'd1);
        tick();
        check_eq("bp1_ready", 256'(in_ready4), 256'(1));
        check_eq("bp1_tag",   256'(out_tag4),  256'(1));
        offer(SEQ4, 1'b1, 4'd2);
        tick();
        check_eq("bp2_ready", 256'(in_ready4), 256'(0));
        check_eq("bp2_tag",   256'(out_tag4),  256'(1));
        offer(FIPS_IN, 1'b0, 4'd3);
        tick();
        check_eq("bp3_ready", 256'(in_ready4),  256'(0));
        check_eq("bp3_valid", 256'(out_valid4), 256'(1));
        check_eq("bp3_tag",   256'(out_tag4),   256'(1));
        check_eq("bp3_data",  256'(out_data4),  256'(FWD4));
        out_ready = 1'b1;
        tick();
        check_eq("bp4_tag",   256'(out_tag4),  256'(2));
        check_eq("bp4_data",  256'(out_data4), 256'(INV4));
        check_eq("bp4_ready", 256'(in_ready4), 256'(1));
        tick();
        check_eq("bp5_tag",  256'(out_tag4),  256'(3));
        check_eq("bp5_data", 256'(out_data4), 256'(FIPS_OUT));
        in_valid = 1'b0;
        tick();
        check_eq("bp6_valid", 256'(out_valid4), 256'(0));

        // Flush while full with a beat offered.
        out_ready = 1'b0;
        offer(SEQ4, 1'b0, 4'd4);
        tick();
        offer(SEQ4, 1'b0, 4'd5);
        tick();
        offer(SEQ4, 1'b0, 4'd6);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_valid", 256'(out_valid4), 256'(0));
        check_eq("fl_ready", 256'(in_ready4),  256'(1));
        out_ready = 1'b1;
        tick();
        check_eq("fl_after_valid", 256'(out_valid4), 256'(0));

        // Flush with one entry and an acceptable beat: the beat is dropped.
        out_ready = 1'b0;
        offer(SEQ4, 1'b0, 4'd9);
        tick();
        offer(SEQ4, 1'b1, 4'd10);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl1_valid", 256'(out_valid4), 256'(0));
        tick();
        check_eq("fl1_after_valid", 256'(out_valid4), 256'(0));

        // Asynchronous reset in mid-cycle with a beat buffered.
        offer(FIPS_IN, 1'b0, 4'd12);
        tick();
        in_valid = 1'b0;
        check_eq("ar_pre_valid", 256'(out_valid4), 256'(1));
        check_eq("ar_pre_tag",   256'(out_tag4),   256'(12));
        #2 rst = 1'b1;
        #1;
        check_eq("ar_valid", 256'(out_valid4), 256'(0));
        check_eq("ar_ready", 256'(in_ready4),  256'(1));
        check_eq("ar_data",  256'(out_data4),  256'(0));
        check_eq("ar_tag",   256'(out_tag4),   256'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("ar_post_valid", 256'(out_valid4), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shiftrows_pipe.md
# shiftrows_pipe

Parametrised, registered ShiftRows/InvShiftRows stage for the Rijndael datapath. It supports block widths Nb = 4, 6 and 8 columns, and the direction is selected per beat. A valid/ready handshake with a 2-entry output buffer lets it sit between the SubBytes and MixColumns stages of a pipelined encrypt/decrypt round without combinational ready paths. It also carries a sideband tag and supports a synchronous flush.

## Interface
- NB, 4: state columns; legal values 4, 6, 8; any other value is an elaboration error.
- TAG_W, 4: sideband tag width, ≥1.
- W (localparam) = 32*NB: state width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of buffered beats.
- in_valid  in  1  input beat present.
- in_ready  out  1  stage can accept; registered.
- in_data  in  W  state, column-major.
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts.
- out_data  out  W  shifted state.
- out_tag  out  TAG_W  tag of the beat on out_data.

## Operation
- Byte index i = r + 4c (r = row 0..3, c = column 0..NB-1) occupies in_data[W-1-8i -: 8], so byte 0 is the MSB.
- Row offsets off(r):
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Forward: out[r][c] = in[r][(c + off(r)) mod NB].
- Inverse: out[r][c] = in[r][(c − off(r)) mod NB].
- Permutation is computed combinationally at the input and written into the buffer on accept; the buffer stores the result and the tag.
- Buffer: 2-entry FIFO with write pointer, read pointer and 2-bit count (0..2).
  - Accept = in_valid & in_ready.
  - Dequeue = out_valid & out_ready.
- Count update per cycle:
  - accept only: +1.
  - dequeue only: −1.
  - both: unchanged, with data order preserved.
  - neither: unchanged.
- Output and ready derivation:
  - out_valid = (count ≠ 0); out_data/out_tag = entry at read pointer.
  - in_ready = register, next value = (next_count < 2).
- Full (count = 2): in_ready is 0, so no accept can occur; a dequeue frees one slot, and in_ready rises the following cycle.
- Empty: out_valid is 0; out_data holds its last value and carries no meaning.
- flush = 1 on a clock edge:
  - count and pointers go to 0, out_valid goes to 0 and in_ready goes to 1 after that edge.
  - A beat offered in the same cycle is dropped, and no dequeue is counted.
  - flush has priority over accept and dequeue.
- Pointers wrap modulo 2.
- in_inv is sampled per beat, so forward and inverse beats may be interleaved freely.

## Timing
- Reset (asynchronous assert, synchronous release): count = 0, pointers = 0, out_valid = 0, in_ready = 1, buffer contents = 0, out_data = 0, out_tag = 0.
- Reset asserted mid-stream discards all buffered beats immediately.
- Latency: a beat accepted at edge N presents on out_data with out_valid = 1 after edge N, i.e. one cycle.
- Throughput: 1 beat/cycle while out_ready = 1 continuously.
- Handshake rules:
  - out_data/out_tag are stable while out_valid = 1 and out_ready = 0.
  - out_valid never drops without a dequeue, flush or reset.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

## Test plan
- NB=4, forward, in_data = 000102…0f, out_ready = 1 → one cycle later out_data = 00050a0f04090e03080d0207 0c01060b.
- NB=4, inverse, in_data = 000102…0f → out_data = 000d0a07 04010e0b 08050 20f 0c090603.
- NB=4, FIPS-197 App. B round 1, in_data = d42711aee0bf98f1b8b45de51e415230 forward → d4bf5d30e0b452aeb84111f11e2798e5. The same vector sent through an inverse beat restores the input.
- NB=8, forward, in_data = bytes 00..1f → first output column 00050e13; NB=6 with bytes 00..17 → first column 00050a0f.
- Backpressure: out_ready = 0, offer 3 beats with tags 1, 2, 3 → in_ready falls after the 2nd accept and beat 3 stalls. Raise out_ready → tags appear in order 1, 2, 3, with no loss or duplication.
- Flush with count = 2 while a beat is offered → next cycle out_valid = 0 and in_ready = 1, and the offered beat never appears. Asynchronous rst mid-stream → outputs take reset values immediately.
